// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter: shares one single-ported memory between fetch and data stages, data-first with bounded fetch starvation
module imem_dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_kill,
  output logic        i_gnt,
  output logic        i_resp,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_rmask,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_resp,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        err_spurious
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, I_DRAIN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic idle, force_i, d_win, i_win;
  assign idle    = state == IDLE;
  assign force_i = i_req & !i_kill & (starve_cnt == CW'(STARVE_LIMIT));
  assign d_win   = !rst & idle & d_req & !force_i;
  assign i_win   = !rst & idle & !d_win & i_req & !i_kill;
  assign i_gnt   = i_win;
  assign d_gnt   = d_win;
  assign mem_req = i_win | d_win;
  // rst gates every output so an abandoned transaction never leaks a response
  always_comb begin
    mem_addr     = d_win ? d_addr : i_win ? i_addr : '0;
    mem_rmask    = d_win ? d_rmask : i_win ? 4'hF : '0;
    mem_wmask    = d_win ? d_wmask : '0;
    mem_wdata    = d_win ? d_wdata : '0;
    i_resp       = !rst & (state == I_WAIT) & mem_resp & !i_kill;
    d_resp       = !rst & (state == D_WAIT) & mem_resp;
    i_rdata      = i_resp ? mem_rdata : '0;
    d_rdata      = d_resp ? mem_rdata : '0;
    err_spurious = !rst & idle & mem_resp;
    state_nxt    = idle ? (d_win ? D_WAIT : i_win ? I_WAIT : IDLE)
                 : mem_resp ? IDLE
                 : (state == I_WAIT && i_kill) ? I_DRAIN : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (i_win || (idle && !i_req))
        starve_cnt <= '0;
      else if (d_win && i_req && !i_kill && starve_cnt != CW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb_imem_dmem_port_arbiter: directed scoreboard bench for the shared memory port arbiter
module tb_imem_dmem_port_arbiter;
  logic clk, rst, i_req, i_kill, d_req, mem_resp;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0] d_rmask, d_wmask;
  logic i_gnt, i_resp, d_gnt, d_resp, mem_req, err_spurious;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_rmask, mem_wmask;
  int n_tests = 0, n_fail = 0;
  typedef struct { logic d; logic [31:0] data; } resp_t;
  resp_t sb[$];
  imem_dmem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_gnt(i_gnt), .i_resp(i_resp), .i_rdata(i_rdata), .d_req(d_req),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_resp(d_resp), .d_rdata(d_rdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .err_spurious(err_spurious)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic d, input logic [31:0] data);
    resp_t e;
    e.d = d;
    e.data = data;
    sb.push_back(e);
  endtask
  // scoreboard: every response must match the oldest expected one
  always @(negedge clk) begin
    chk("gnt_exclusive", {31'd0, i_gnt & d_gnt}, 32'd0);
    if (i_resp || d_resp) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_resp observed=i%0b/d%0b expected=none", i_resp, d_resp);
      end
      if (sb.size() != 0) begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_owner", {31'd0, d_resp}, {31'd0, e.d});
        chk("resp_data", d_resp ? d_rdata : i_rdata, e.data);
      end
    end
  end
  initial begin
    #100000;
    $error("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1; i_req = 0; i_kill = 0; d_req = 0; mem_resp = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0; d_rmask = 0; d_wmask = 0;
    tick(); tick();
    i_req = 1; d_req = 1; mem_resp = 1; #1;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_gnts", {30'd0, i_gnt, d_gnt}, 0);
    chk("rst_err", {31'd0, err_spurious}, 0);
    i_req = 0; d_req = 0; mem_resp = 0;
    tick(); rst = 0; #1;
    chk("idle_mem_req", {31'd0, mem_req}, 0);
    chk("idle_state", 32'(dut.state), 0);
    // 1: fetch only, 3-cycle memory latency
    tick(); i_req = 1; i_addr = 32'h6000_0000; #1;
    chk("t1_i_gnt", {31'd0, i_gnt}, 1);
    chk("t1_mem_addr", mem_addr, 32'h6000_0000);
    chk("t1_rmask", {28'd0, mem_rmask}, 32'hF);
    chk("t1_wmask", {28'd0, mem_wmask}, 0);
    push(0, 32'h13);
    tick(); i_req = 0; #1;
    chk("t1_wait_req", {31'd0, mem_req}, 0);
    tick();
    tick(); mem_resp = 1; mem_rdata = 32'h13; #1;
    chk("t1_i_resp", {31'd0, i_resp}, 1);
    chk("t1_i_rdata", i_rdata, 32'h13);
    // 2: simultaneous requests, data wins
    tick(); mem_resp = 0; mem_rdata = 0;
    i_req = 1; i_addr = 32'h6000_0004;
    d_req = 1; d_addr = 32'h100; d_rmask = 0; d_wmask = 4'b0011; d_wdata = 32'hDEAD_BEEF; #1;
    chk("t2_d_gnt", {31'd0, d_gnt}, 1);
    chk("t2_i_gnt", {31'd0, i_gnt}, 0);
    chk("t2_wmask", {28'd0, mem_wmask}, 3);
    chk("t2_rmask", {28'd0, mem_rmask}, 0);
    chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_addr", mem_addr, 32'h100);
    push(1, 0);
    tick(); d_req = 0; mem_resp = 1; #1;
    chk("t2_d_resp", {31'd0, d_resp}, 1);
    chk("t2_no_gnt_in_resp", {31'd0, i_gnt}, 0);
    tick(); mem_resp = 0; #1;
    chk("t2_i_gnt_after", {31'd0, i_gnt}, 1);
    chk("t2_i_addr", mem_addr, 32'h6000_0004);
    push(0, 32'h1234);
    tick(); i_req = 0; mem_resp = 1; mem_rdata = 32'h1234; #1;
    // 3: starvation bound, both requests held
    for (int k = 0; k < 5; k++) begin
      tick(); mem_resp = 0;
      i_req = 1; i_addr = 32'h6000_0008; d_req = 1; d_addr = 32'h200; d_rmask = 4'hF; d_wmask = 0; #1;
      if (k == 4) chk("t3_cnt_sat", 32'(dut.starve_cnt), 4);
      chk($sformatf("t3_d_gnt%0d", k), {31'd0, d_gnt}, {31'd0, k < 4});
      chk($sformatf("t3_i_gnt%0d", k), {31'd0, i_gnt}, {31'd0, k == 4});
      push(k == 4 ? 1'b0 : 1'b1, 32'(k));
      tick(); mem_resp = 1; mem_rdata = 32'(k);
      if (k == 4) i_req = 0;
      #1;
    end
    chk("t3_cnt_clear", 32'(dut.starve_cnt), 0);
    // 4: kill after grant drains the response
    tick(); mem_resp = 0; d_req = 0; i_req = 1; i_addr = 32'h40; #1;
    chk("t4_i_gnt", {31'd0, i_gnt}, 1);
    tick(); i_req = 0; i_kill = 1; #1;
    chk("t4_kill_resp", {31'd0, i_resp}, 0);
    tick(); i_kill = 0; #1;
    chk("t4_drain_state", 32'(dut.state), 3);
    tick(); mem_resp = 1; mem_rdata = 32'hBAD; #1;
    chk("t4_drain_resp", {31'd0, i_resp}, 0);
    chk("t4_drain_rdata", i_rdata, 0);
    chk("t4_drain_err", {31'd0, err_spurious}, 0);
    tick(); mem_resp = 0; d_req = 1; d_addr = 32'h300; d_rmask = 4'hF; d_wmask = 0; #1;
    chk("t4_next_gnt", {31'd0, d_gnt}, 1);
    push(1, 32'h55);
    tick(); d_req = 0; mem_resp = 1; mem_rdata = 32'h55; #1;
    // 5: kill coincident with response, then kill in IDLE
    tick(); mem_resp = 0; i_req = 1; i_addr = 32'h80; #1;
    chk("t5_i_gnt", {31'd0, i_gnt}, 1);
    tick(); i_req = 0; i_kill = 1; mem_resp = 1; mem_rdata = 32'h77; #1;
    chk("t5_kill_resp", {31'd0, i_resp}, 0);
    tick(); mem_resp = 0; i_req = 1; i_kill = 1; #1;
    chk("t5_idle_state", 32'(dut.state), 0);
    chk("t5_kill_blocks_gnt", {31'd0, i_gnt}, 0);
    chk("t5_kill_no_req", {31'd0, mem_req}, 0);
    tick(); i_kill = 0; #1;
    chk("t5_gnt_after_kill", {31'd0, i_gnt}, 1);
    push(0, 32'h99);
    tick(); i_req = 0; mem_resp = 1; mem_rdata = 32'h99; #1;
    // 6: reset while data outstanding, then a stale response
    tick(); mem_resp = 0; d_req = 1; d_addr = 32'h400; d_rmask = 4'hF; #1;
    chk("t6_d_gnt", {31'd0, d_gnt}, 1);
    tick(); d_req = 0; rst = 1; #1;
    chk("t6_rst_d_resp", {31'd0, d_resp}, 0);
    tick(); rst = 0; mem_resp = 1; mem_rdata = 32'hAA; #1;
    chk("t6_stale_d_resp", {31'd0, d_resp}, 0);
    chk("t6_stale_rdata", d_rdata, 0);
    chk("t6_err", {31'd0, err_spurious}, 1);
    chk("t6_mem_req", {31'd0, mem_req}, 0);
    tick(); mem_resp = 0; #1;
    chk("t6_err_clear", {31'd0, err_spurious}, 0);
    tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
